message_schedule: RTL
=====================

Name: message_schedule

Overview:
- Consumes the padded 512-bit blocks that message_build produces.
- Expands each block into the 64-word SHA-256 message schedule W0..W63 and emits one 32-bit word per handshake to the downstream compression stage.
- Uses a 16-word sliding window, so one new word is computed per output word with no stall cycles.
- Sits between message_build (upstream) and the hash compression core (downstream).

Parameters:
- ROUNDS, 64, words emitted per block. Must be at least 16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  512  padded block. W0 = data_in[511:480], W15 = data_in[31:0] (big-endian word order).
- data_in_valid  input  1  block valid.
- data_in_ready  output  1  block accepted when valid & ready.
- data_in_last  input  1  block is the final block of the message. Sampled on acceptance.
- data_out  output  32  schedule word Wt.
- data_out_valid  output  1  word valid.
- data_out_ready  input  1  downstream accepts the word.
- data_out_blk_last  output  1  high with W(ROUNDS-1) of every block.
- data_out_last  output  1  high with W(ROUNDS-1) of a block accepted with data_in_last=1.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, window cleared, last flag cleared.
  - data_out=0, data_out_valid=0, data_out_blk_last=0, data_out_last=0.
  - data_in_ready=1 once rst deasserts.
- States: IDLE and EMIT.
- IDLE:
  - data_in_ready=1, data_out_valid=0.
  - On data_in handshake: load window w[0..15] = W0..W15, cnt=0, latch data_in_last, go to EMIT.
- EMIT:
  - data_out = w[0], data_out_valid=1.
  - On output handshake:
    - shift window: w[i] <= w[i+1] for i=0..14.
    - w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32.
    - cnt <= cnt+1.
- Arithmetic:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All adds are 32-bit with carries discarded.
  - The new word is computed unconditionally; words beyond ROUNDS are never emitted.
- Latency: block accepted at edge N; W0 is valid after edge N (first cycle following the handshake). After that, one word per cycle while data_out_ready=1.
- Backpressure: while data_out_valid & !data_out_ready, data_out and both last flags hold stable and the window does not shift.
- End of block: with cnt=ROUNDS-1, data_out_blk_last=1 and data_out_last = latched flag.
- On the final-word handshake:
  - data_in_ready = 1 combinationally in that same cycle (data_in_ready = IDLE | (cnt==ROUNDS-1 & data_out_valid & data_out_ready)).
  - If data_in_valid is also high, the next block loads directly and state stays EMIT: back-to-back blocks with no bubble.
  - Otherwise go to IDLE.
- data_in_ready is 0 in EMIT in every other cycle. Inputs presented then are not sampled.
- cnt is 6 bits for ROUNDS=64, width $clog2(ROUNDS). It never wraps: it resets to 0 on each load.
- rst asserted mid-block: the partial schedule is discarded and no further words are emitted. Upstream must re-present the block after reset.
- No combinational path from data_in to data_out. Only data_in_ready depends combinationally on data_out_ready.

Decomposition:
- Shared package sha2_pkg:
  - word_t (logic [31:0]).
  - block_t (logic [511:0]).
  - functions sha256_sigma0 and sha256_sigma1.
  - state enum sched_state_t {IDLE, EMIT}.
  - constant SHA256_ROUNDS=64.
- The package is reused by the compression core, which adds the big-Sigma functions and the K constants.
- No sub-module: window, counter and FSM live in one module.

Test Plan:
- "abc" padded block (0x61626380, 14 zero words, 0x00000018), data_in_last=1, data_out_ready=1 ->
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - 64 words total in 64 consecutive cycles.
  - data_out_blk_last=1 and data_out_last=1 only on W63.
- Two blocks back-to-back (first last=0, second last=1), data_in_valid held high ->
  - second block accepted in the W63 handshake cycle of the first; W0 of block 2 appears on the next cycle with no gap.
  - data_out_last=0 on the first block's W63 and 1 on the second block's W63.
- Random data_out_ready deassertion during "abc" -> data_out stable while stalled; the word sequence is identical to scenario 1 and matches a software SHA-256 schedule model.
- data_in_valid asserted during EMIT at cnt=10 -> data_in_ready=0 and the block is not accepted until the W63 handshake.
- rst pulsed at cnt=20 -> data_out_valid=0 asynchronously; after release state is IDLE with data_in_ready=1, and a new block restarts from W0.
- All-ones block 0xFFFF...FFFF -> W16 equals the 32-bit wrapped sum from the reference model, checking mod 2^32 overflow.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions.
// Purpose: word/block types, the small-sigma message schedule functions,
//          the schedule FSM state type and the SHA-256 round count. The
//          compression core imports this package too and adds the big-Sigma
//          functions and the K constants alongside.
// Ports:   none (package).
package sha2_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sched_state_t;

  localparam int SHA256_ROUNDS = 64;
  localparam int WINDOW_WORDS  = 16;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sha256_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sha256_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_schedule_if.sv
// Block-in / word-out stream bundle for the SHA-256 message schedule.
// Purpose: groups the upstream block handshake (from message_build) and the
//          downstream word handshake (to the compression core).
// Signals: data_in/_valid/_last, data_in_ready      - block stream
//          data_out/_valid, data_out_ready,
//          data_out_blk_last, data_out_last          - word stream
// Modports: slave  - the schedule block itself
//           master - the environment driving blocks and accepting words
interface message_schedule_if;
  import sha2_pkg::*;

  block_t data_in;
  logic   data_in_valid;
  logic   data_in_ready;
  logic   data_in_last;

  word_t  data_out;
  logic   data_out_valid;
  logic   data_out_ready;
  logic   data_out_blk_last;
  logic   data_out_last;

  modport slave (
    input  data_in, data_in_valid, data_in_last, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_blk_last, data_out_last
  );

  modport master (
    output data_in, data_in_valid, data_in_last, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_blk_last, data_out_last
  );

endinterface

// File: rtl/message_schedule.sv
// SHA-256 message schedule expander.
// Purpose: accepts a padded 512-bit block, emits W0..W(ROUNDS-1) one word per
//          downstream handshake using a 16-word sliding window, and can take
//          the next block in the same cycle as the final word handshake so
//          consecutive blocks stream without a bubble.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset
//          bus  - message_schedule_if.slave (block in, word out)
// Parameter ROUNDS: words emitted per block, must be at least 16.
module message_schedule
  import sha2_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input logic               clk,
  input logic               rst,
  message_schedule_if.slave bus
);

  localparam int              CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  sched_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  word_t            win_q [WINDOW_WORDS];
  logic             last_q;

  word_t new_word_d;
  logic  emit;
  logic  at_last;
  logic  out_hs;
  logic  final_hs;
  logic  in_hs;

  assign emit     = (state_q == EMIT);
  assign at_last  = (cnt_q == LAST_CNT);
  assign out_hs   = emit & bus.data_out_ready;
  assign final_hs = out_hs & at_last;
  assign in_hs    = bus.data_in_valid & bus.data_in_ready;

  // Next schedule word from the current window. Computed every cycle; it is
  // only committed on a non-final shift, so words past ROUNDS never appear.
  assign new_word_d = sha256_sigma1(win_q[14]) + win_q[9]
                    + sha256_sigma0(win_q[1]) + win_q[0];

  // The only combinational input-to-output path: the final word handshake
  // frees the window for the next block in the same cycle.
  assign bus.data_in_ready     = !emit | final_hs;

  assign bus.data_out          = win_q[0];
  assign bus.data_out_valid    = emit;
  assign bus.data_out_blk_last = emit & at_last;
  assign bus.data_out_last     = emit & at_last & last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < WINDOW_WORDS; i++) win_q[i] <= '0;
    end else if (in_hs) begin
      // Fresh block (from IDLE or chained onto the final word): W0 lands in
      // win_q[0] and is presented on the very next cycle.
      state_q <= EMIT;
      cnt_q   <= '0;
      last_q  <= bus.data_in_last;
      for (int i = 0; i < WINDOW_WORDS; i++) win_q[i] <= bus.data_in[511-32*i -: 32];
    end else if (out_hs) begin
      if (final_hs) begin
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        for (int i = 0; i < WINDOW_WORDS - 1; i++) win_q[i] <= win_q[i+1];
        win_q[WINDOW_WORDS-1] <= new_word_d;
      end
    end
  end

endmodule
